// File: rtl/led_pattern_counter_if.sv
// rtl/led_pattern_counter_if.sv - control/display bundle for led_pattern_counter
//
// Purpose : groups the run/clear/mode controls and the registered display
//           outputs of led_pattern_counter into one port.
// Signals : clr      - synchronous clear, active high
//           en       - run (1) / pause (0)
//           mode     - 00 up, 01 down, 10 bounce, 11 ring
//           led_out  - registered display value, WIDTH bits
//           tick     - one-cycle pulse on each advance
//           wrap     - one-cycle pulse on sequence wrap (only with tick)
// Modports: master drives the controls and watches the display,
//           slave is the counter itself.

interface led_pattern_counter_if #(
  parameter int WIDTH = 8
) ();

  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led_out;
  logic             tick;
  logic             wrap;

  modport master (
    output clr,
    output en,
    output mode,
    input  led_out,
    input  tick,
    input  wrap
  );

  modport slave (
    input  clr,
    input  en,
    input  mode,
    output led_out,
    output tick,
    output wrap
  );

endinterface

// File: rtl/led_pattern_counter.sv
// rtl/led_pattern_counter.sv - tick-paced LED counter with up/down/bounce/ring modes
//
// Purpose : a prescaler divides clk_i by DIV = CLK_FREQ/TICK_HZ; every DIV
//           enabled cycles the display value advances according to MODE.
//           A clear or a change of MODE reloads the start value of the new
//           mode and restarts the prescaler; the reload beats a coinciding
//           advance.
// Ports   : clk_i    - system clock, rising edge
//           rst_n_i  - asynchronous active-low reset
//           bus      - led_pattern_counter_if.slave (clr, en, mode in;
//                      led_out, tick, wrap out, all registered)
// Params  : CLK_FREQ (Hz), TICK_HZ (Hz), DIV legal 2..2^24;
//           WIDTH legal 2..16.
// Macro   : LED_COUNTER_GRAY_EN - when defined, led_out shows the Gray code
//           of the count in up, down and bounce modes; ring mode, tick and
//           wrap are unaffected. Undefined: led_out is the count itself.

module led_pattern_counter #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int TICK_HZ  = 1,
  parameter int WIDTH    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  led_pattern_counter_if.slave bus
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  localparam logic [PW-1:0]    PCNT_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);

  // Count modes, kept as plain constants so the encoding matches the pins.
  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RING   = 2'b11;

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic             dir_q,  dir_d;   // bounce direction, 0 = up
  logic [1:0]       mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic             reload;
  logic             cnt_onehot;

  function automatic logic [WIDTH-1:0] start_value(input logic [1:0] m);
    case (m)
      MODE_DOWN: start_value = CNT_MAX;
      MODE_RING: start_value = CNT_ONE;
      default:   start_value = '0;
    endcase
  endfunction

  // A clear and a mode change are the same operation: both restart the
  // sequence from the start value of the mode presented on the pins.
  assign reload = bus.clr || (bus.mode != mode_q);

  // Ring mode only rotates a single lit bit; anything else is repaired.
  assign cnt_onehot = (cnt_q != '0) && ((cnt_q & (cnt_q - CNT_ONE)) == '0);

  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (reload) begin
      pcnt_d = '0;
      cnt_d  = start_value(bus.mode);
      dir_d  = 1'b0;
      mode_d = bus.mode;
    end else if (bus.en) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_UP: begin
            cnt_d  = cnt_q + CNT_ONE;
            wrap_d = (cnt_q == CNT_MAX);
          end
          MODE_DOWN: begin
            cnt_d  = cnt_q - CNT_ONE;
            wrap_d = (cnt_q == '0);
          end
          MODE_BOUNCE: begin
            // Direction turns on the tick that lands on an endpoint, so
            // neither endpoint is shown twice. A zero count always climbs,
            // which also keeps an inconsistent dir from underflowing.
            if ((cnt_q == '0) || (!dir_q && (cnt_q != CNT_MAX))) begin
              cnt_d = cnt_q + CNT_ONE;
              dir_d = (cnt_q == (CNT_MAX - CNT_ONE));
            end else begin
              cnt_d = cnt_q - CNT_ONE;
              dir_d = 1'b1;
              if (cnt_q == CNT_ONE) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end
            end
          end
          default: begin
            if (cnt_onehot) begin
              cnt_d  = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
              wrap_d = cnt_q[WIDTH-1];
            end else begin
              cnt_d  = CNT_ONE;
            end
          end
        endcase
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= MODE_UP;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

`ifdef LED_COUNTER_GRAY_EN
  // The display is encoded from the next count so it changes on the same
  // edge as cnt; mode_d selects the encoding so a reload into or out of
  // ring mode shows the right form immediately.
  logic [WIDTH-1:0] led_q, led_d;

  always_comb begin
    led_d = cnt_d;
    if (mode_d != MODE_RING) begin
      led_d = cnt_d ^ (cnt_d >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign bus.led_out = led_q;
`else
  assign bus.led_out = cnt_q;
`endif

endmodule
